// File: rtl/led_frame_sched.sv
// Frame scheduler for the MiniLED sdbp RAM write port: waits out driver init, ticks a
// fixed frame period, pulses sdbpflag, then streams N_LED pixel words into the LED RAM.
module led_frame_sched #(
    parameter int N_LED        = 360,
    parameter int INIT_CYCLES  = 2500,
    parameter int FRAME_CYCLES = 420000,
    parameter int FLAG_CYCLES  = 29,
    parameter int DW           = 16,
    parameter int AW           = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          px_valid,
    input  logic [DW-1:0] px_data,
    output logic          px_ready,
    output logic [AW-1:0] px_idx,
    output logic          sdbpflag,
    output logic          wten,
    output logic [AW-1:0] wtaddr,
    output logic [DW-1:0] wtdina,
    output logic          busy,
    output logic          frame_done,
    output logic [7:0]    skip_cnt
);

    localparam int IW = (INIT_CYCLES  > 1) ? $clog2(INIT_CYCLES)  : 1;
    localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int GW = (FLAG_CYCLES  > 1) ? $clog2(FLAG_CYCLES)  : 1;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_FLAG,
        S_LOAD
    } state_t;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } wr_t;

    state_t        state, state_nxt;
    logic [IW-1:0] init_cnt;
    logic [FW-1:0] fcnt;
    logic [GW-1:0] flag_cnt;
    logic [AW-1:0] idx;
    logic [7:0]    skip_q;
    wr_t           wr_q;

    logic tick, init_last, flag_last, last_word, accept, in_busy;

    assign init_last = (init_cnt == IW'(INIT_CYCLES - 1));
    assign flag_last = (flag_cnt == GW'(FLAG_CYCLES - 1));
    assign last_word = (idx == AW'(N_LED - 1));
    assign tick      = (fcnt == '0) && (state != S_INIT);
    assign accept    = px_valid && (state == S_LOAD);
    assign in_busy   = (state == S_FLAG) || (state == S_LOAD);

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: if (init_last)             state_nxt = S_IDLE;
            S_IDLE: if (tick && enable)        state_nxt = S_FLAG;
            S_FLAG: if (flag_last)             state_nxt = S_LOAD;
            S_LOAD: if (accept && last_word)   state_nxt = S_IDLE;
            default:                           state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_INIT;
            init_cnt <= '0;
            fcnt     <= '0;
            flag_cnt <= '0;
            idx      <= '0;
            skip_q   <= '0;
            wr_q     <= '0;
        end else begin
            state <= state_nxt;

            init_cnt <= (state == S_INIT && !init_last) ? init_cnt + 1'b1 : '0;

            // frame timebase is frozen at 0 during INIT so the first tick lands on the first IDLE cycle
            if (state == S_INIT)
                fcnt <= '0;
            else
                fcnt <= (fcnt == FW'(FRAME_CYCLES - 1)) ? '0 : fcnt + 1'b1;

            flag_cnt <= (state == S_FLAG && !flag_last) ? flag_cnt + 1'b1 : '0;

            if (state != S_LOAD)
                idx <= '0;
            else if (accept)
                idx <= last_word ? '0 : idx + 1'b1;

            if (tick && in_busy && skip_q != 8'hFF)
                skip_q <= skip_q + 1'b1;

            // write port is zero on stall cycles, not just gated by wten
            wr_q.en   <= accept;
            wr_q.addr <= accept ? idx : '0;
            wr_q.data <= accept ? px_data : '0;
            wr_q.last <= accept && last_word;
        end
    end

    assign sdbpflag   = (state == S_FLAG);
    assign busy       = in_busy;
    assign px_ready   = (state == S_LOAD);
    assign px_idx     = (state == S_LOAD) ? idx : '0;
    assign wten       = wr_q.en;
    assign wtaddr     = wr_q.addr;
    assign wtdina     = wr_q.data;
    assign frame_done = wr_q.last;
    assign skip_cnt   = skip_q;

    a_addr_range: assert property (@(posedge clk) disable iff (!rst_n)
        wten |-> (wtaddr <= AW'(N_LED - 1)));
    a_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
        idx <= AW'(N_LED - 1));

endmodule

// File: tb/tb_led_frame_sched.sv
// Randomized/directed bench for led_frame_sched against a frame-timeline reference model.
module tb_led_frame_sched;
    localparam int N   = 8;
    localparam int IC  = 8;
    localparam int FC  = 64;
    localparam int FLC = 3;
    localparam int DW  = 16;
    localparam int AW  = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          px_valid = 1'b0;
    logic [DW-1:0] px_data = '0;
    logic          px_ready, sdbpflag, wten, busy, frame_done;
    logic [AW-1:0] px_idx, wtaddr;
    logic [DW-1:0] wtdina;
    logic [7:0]    skip_cnt;

    always #5 clk = ~clk;

    led_frame_sched #(
        .N_LED(N), .INIT_CYCLES(IC), .FRAME_CYCLES(FC), .FLAG_CYCLES(FLC), .DW(DW), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .px_valid(px_valid), .px_data(px_data),
        .px_ready(px_ready), .px_idx(px_idx), .sdbpflag(sdbpflag), .wten(wten),
        .wtaddr(wtaddr), .wtdina(wtdina), .busy(busy), .frame_done(frame_done),
        .skip_cnt(skip_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;

    // reference model: cycles since reset, frame phase as countdown/index
    int m_cyc, m_flag, m_idx, m_skip, m_waddr, m_wdata;
    bit m_load, m_wten, m_fd;

    int mode, stall, wr_cnt, done_cnt;
    bit prev_flag;
    int flag_rises[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, m_cyc);
        end
    endtask

    task automatic model_step();
        bit tk, acc;
        if (!rst_n) begin
            m_cyc = 0; m_flag = 0; m_idx = 0; m_skip = 0; m_load = 0;
            m_wten = 0; m_waddr = 0; m_wdata = 0; m_fd = 0;
        end else begin
            tk  = (m_cyc >= IC) && (((m_cyc - IC) % FC) == 0);
            acc = m_load && px_valid;
            if (tk && (m_flag > 0 || m_load) && m_skip < 255) m_skip++;
            m_wten  = acc;
            m_waddr = acc ? m_idx : 0;
            m_wdata = acc ? int'(px_data) : 0;
            m_fd    = acc && (m_idx == N - 1);
            if (m_flag > 0) begin
                m_flag--;
                if (m_flag == 0) begin m_load = 1; m_idx = 0; end
            end else if (m_load) begin
                if (acc) begin
                    if (m_idx == N - 1) m_load = 0;
                    else m_idx++;
                end
            end else if (tk && enable) begin
                m_flag = FLC;
            end
            m_cyc++;
        end
    endtask

    task automatic compare_all();
        chk("sdbpflag",   sdbpflag,   m_flag > 0);
        chk("busy",       busy,       (m_flag > 0) || m_load);
        chk("px_ready",   px_ready,   m_load);
        chk("px_idx",     px_idx,     m_load ? m_idx : 0);
        chk("wten",       wten,       m_wten);
        chk("wtaddr",     wtaddr,     m_waddr);
        chk("wtdina",     wtdina,     m_wdata);
        chk("frame_done", frame_done, m_fd);
        chk("skip_cnt",   skip_cnt,   m_skip);
        if (!rst_n) begin
            wr_cnt = 0;
        end else begin
            if (wten) wr_cnt++;
            if (frame_done) begin
                chk("frame_len", wr_cnt, N);
                wr_cnt = 0;
                done_cnt++;
            end
        end
        if (sdbpflag && !prev_flag) flag_rises.push_back(m_cyc);
        prev_flag = sdbpflag;
    endtask

    task automatic drive();
        case (mode)
            1: px_valid = ~px_valid;
            2: begin
                px_valid = !(m_load && stall < 70);
                if (m_load && !px_valid) stall++;
            end
            3: begin
                px_valid = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 99) == 0) enable = ~enable;
            end
            default: ;
        endcase
        px_data = (mode == 3) ? DW'($urandom) : DW'(16'h1100 + m_idx);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all();
            drive();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        flag_rises.delete();
        done_cnt = 0;
        prev_flag = 0;
        stall = 0;
    endtask

    initial begin
        int t_en, t_tick;
        m_cyc = 0; m_flag = 0; m_idx = 0; m_skip = 0; m_load = 0;
        m_wten = 0; m_waddr = 0; m_wdata = 0; m_fd = 0;
        wr_cnt = 0; done_cnt = 0; prev_flag = 0; stall = 0;

        // 1: free-running frames
        mode = 0; enable = 1; px_valid = 1;
        do_reset();
        run(140);
        chk("t1_flag_cnt", flag_rises.size(), 3);
        if (flag_rises.size() >= 2) begin
            chk("t1_first_flag", flag_rises[0], 9);
            chk("t1_second_flag", flag_rises[1], 73);
        end
        chk("t1_frames", done_cnt, 2);

        // 2: alternating valid
        mode = 1; px_valid = 1;
        do_reset();
        run(140);
        chk("t2_frames", done_cnt, 2);

        // 3: long stall across a tick
        mode = 2; px_valid = 1;
        do_reset();
        run(125);
        chk("t3_skip", skip_cnt, 1);
        chk("t3_flags", flag_rises.size(), 1);
        chk("t3_frames", done_cnt, 1);

        // 4: disabled, then enabled
        mode = 0; enable = 0; px_valid = 1;
        do_reset();
        run(200);
        chk("t4_noflag", flag_rises.size(), 0);
        chk("t4_skip", skip_cnt, 0);
        chk("t4_nowrites", done_cnt, 0);
        enable = 1;
        t_en = m_cyc;
        t_tick = IC + ((t_en - IC + FC - 1) / FC) * FC;
        run(100);
        chk("t4_flag_count", flag_rises.size() > 0, 1);
        if (flag_rises.size() > 0) chk("t4_flag_at", flag_rises[0], t_tick + 1);

        // 5: reset at write idx 4
        mode = 0; enable = 1; px_valid = 1;
        do_reset();
        for (int i = 0; i < 200 && !(m_wten && m_waddr == 4); i++) run(1);
        chk("t5_reached_idx4", m_wten && m_waddr == 4, 1);
        do_reset();
        chk("t5_wten_after_rst", wten, 0);
        run(100);
        chk("t5_frames", done_cnt, 2);

        // 6: skip counter saturation
        mode = 0; enable = 1; px_valid = 0;
        do_reset();
        run(300 * FC + 100);
        chk("t6_skip_sat", skip_cnt, 255);

        // random traffic with occasional resets
        mode = 3; enable = 1;
        do_reset();
        for (int r = 0; r < 8; r++) begin
            run($urandom_range(200, 600));
            if ($urandom_range(0, 1) == 1) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
